// File: rtl/jt49_eg_timebase_if.sv
// Register-bus and envelope-timebase signal bundle for jt49_eg_timebase.
// master drives the write strobe/data and cen; slave returns readback and timebase outputs.
interface jt49_eg_timebase_if;
    logic       cen;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       step;
    logic       null_period;
    logic       restart;
    logic [3:0] ctrl;

    modport master (
        output cen, wr, addr, din,
        input  dout, step, null_period, restart, ctrl
    );

    modport slave (
        input  cen, wr, addr, din,
        output dout, step, null_period, restart, ctrl
    );
endinterface

// File: rtl/jt49_eg_timebase.sv
// Envelope timebase: period/shape registers, cen prescaler by DIV, period counter
// driving the step square wave, restart pulse on shape writes and null-period flag.
module jt49_eg_timebase #(
    parameter int unsigned DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    jt49_eg_timebase_if.slave bus
);
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [15:0]   period_q, period_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          null_q, null_d;
    logic          restart_q, restart_d;
    logic [7:0]    dout_q, dout_d;
    logic          shape_wr;
    logic          tick;

    always_comb begin
        period_d  = period_q;
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        shape_wr  = bus.wr && (bus.addr == 2'd2);
        tick      = bus.cen && (presc_q == PMAX);
        restart_d = shape_wr;

        // Readback samples the registers before this clk's write lands.
        case (bus.addr)
            2'd0:    dout_d = period_q[7:0];
            2'd1:    dout_d = period_q[15:8];
            2'd2:    dout_d = {4'h0, ctrl_q};
            default: dout_d = 8'h00;
        endcase

        if (bus.wr) begin
            case (bus.addr)
                2'd0:    period_d[7:0]  = bus.din;
                2'd1:    period_d[15:8] = bus.din;
                2'd2:    ctrl_d         = bus.din[3:0];
                default: ;
            endcase
        end

        // A shape write overrides any tick or wrap scheduled for the same clk.
        if (shape_wr) begin
            presc_d = '0;
            cnt_d   = '0;
            step_d  = 1'b0;
        end else if (bus.cen) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (period_q == '0) begin
                    cnt_d = '0;
                end else if (cnt_q >= period_q - 16'd1) begin
                    cnt_d  = '0;
                    step_d = ~step_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end

        null_d = (period_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            ctrl_q    <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            null_q    <= 1'b1;
            restart_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            period_q  <= period_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            null_q    <= null_d;
            restart_q <= restart_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.step        = step_q;
    assign bus.null_period = null_q;
    assign bus.restart     = restart_q;
    assign bus.ctrl        = ctrl_q;
endmodule

// File: tb/tb_jt49_eg_timebase.sv
// Scoreboard bench for jt49_eg_timebase: randomized and directed register/cen stimulus
// against a cen-count reference model; separate check of the 16'hFFFF wrap with DIV=1.
module tb_jt49_eg_timebase;
    localparam int unsigned DIV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_drv = 1'b0;
    always #5 clk = ~clk;

    jt49_eg_timebase_if bus0 ();
    jt49_eg_timebase_if bus1 ();

    jt49_eg_timebase #(.DIV(DIV)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
    jt49_eg_timebase #(.DIV(1))   u_dut_div1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic       step;
        logic       nul;
        logic       restart;
        logic [3:0] ctrl;
        logic [7:0] dout;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    // Reference model: counts cen pulses and period ticks since the last clear.
    logic [15:0] m_period;
    logic [3:0]  m_ctrl;
    logic        m_step, m_null, m_restart;
    logic [7:0]  m_dout;
    int unsigned m_cen_cnt, m_ticks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_period = '0; m_ctrl = '0; m_step = 1'b0; m_null = 1'b1;
        m_restart = 1'b0; m_dout = '0; m_cen_cnt = 0; m_ticks = 0;
    endfunction

    function automatic bit toggle_next(input bit cen);
        return cen && (m_cen_cnt % DIV == DIV - 1) && (m_period != 0) &&
               (m_ticks + 1 >= m_period);
    endfunction

    function automatic void model_step(input bit cen, input bit wr, input logic [1:0] a,
                                       input logic [7:0] d);
        bit shape;
        shape = wr && (a == 2'd2);
        case (a)
            2'd0:    m_dout = m_period[7:0];
            2'd1:    m_dout = m_period[15:8];
            2'd2:    m_dout = {4'h0, m_ctrl};
            default: m_dout = 8'h00;
        endcase
        if (shape) begin
            m_cen_cnt = 0; m_ticks = 0; m_step = 1'b0;
        end else if (cen) begin
            if (m_cen_cnt % DIV == DIV - 1) begin
                if (m_period == 0) m_ticks = 0;
                else if (m_ticks + 1 >= m_period) begin
                    m_step = ~m_step; m_ticks = 0;
                end else m_ticks++;
            end
            m_cen_cnt++;
        end
        if (wr && a == 2'd0) m_period[7:0] = d;
        if (wr && a == 2'd1) m_period[15:8] = d;
        if (shape) m_ctrl = d[3:0];
        m_null = (m_period == 0);
        m_restart = shape;
    endfunction

    function automatic exp_t cur_exp();
        exp_t e;
        e.step = m_step; e.nul = m_null; e.restart = m_restart; e.ctrl = m_ctrl; e.dout = m_dout;
        return e;
    endfunction

    task automatic cyc(input bit cen, input bit wr, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        rst_n = rst_drv;
        bus0.cen = cen; bus0.wr = wr; bus0.addr = a; bus0.din = d;
        if (rst_n) model_step(cen, wr, a, d);
        else model_reset();
        sb_q.push_back(cur_exp());
        mon_en = 1'b1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        rst_drv = 1'b0;
        #1;
        chk("async_step", bus0.step, 1'b0);
        chk("async_null", bus0.null_period, 1'b1);
        chk("async_restart", bus0.restart, 1'b0);
        chk("async_ctrl", bus0.ctrl, 4'h0);
        chk("async_dout", bus0.dout, 8'h00);
        sb_q.delete();
        model_reset();
        sb_q.push_back(cur_exp());
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=0 required=1 t=%0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("step", bus0.step, e.step);
                chk("null_period", bus0.null_period, e.nul);
                chk("restart", bus0.restart, e.restart);
                chk("ctrl", bus0.ctrl, e.ctrl);
                chk("dout", bus0.dout, e.dout);
            end
        end
    end

    initial begin
        int n;
        bus0.cen = 1'b0; bus0.wr = 1'b0; bus0.addr = '0; bus0.din = '0;
        bus1.cen = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.din = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_drv = 1'b1;

        // Idle after reset: nothing may move.
        repeat (1000) cyc(1'b1, 1'b0, 2'd0, 8'h00);

        // Period 3, cen every clk.
        cyc(1'b1, 1'b1, 2'd0, 8'h03);
        repeat (200) cyc(1'b1, 1'b0, 2'd0, 8'h00);

        // Shape write, then back-to-back shape writes.
        cyc(1'b1, 1'b1, 2'd2, 8'h0E);
        repeat (60) cyc(1'b1, 1'b0, 2'd2, 8'h00);
        cyc(1'b1, 1'b1, 2'd2, 8'h03);
        cyc(1'b1, 1'b1, 2'd2, 8'h0A);
        repeat (10) cyc(1'b1, 1'b0, 2'd2, 8'h00);

        // Period shrunk below the running count.
        cyc(1'b1, 1'b1, 2'd0, 8'd20);
        cyc(1'b1, 1'b1, 2'd2, 8'h0E);
        n = 0;
        while (!(m_ticks == 10 && m_cen_cnt % DIV == 0) && n < 1000) begin
            cyc(1'b1, 1'b0, 2'd0, 8'h00); n++;
        end
        chk("reach_count10", n < 1000, 1'b1);
        cyc(1'b1, 1'b1, 2'd0, 8'd5);
        repeat (100) cyc(1'b1, 1'b0, 2'd1, 8'h00);

        // Shape write landing on a scheduled toggle.
        n = 0;
        while (!toggle_next(1'b1) && n < 1000) begin
            cyc(1'b1, 1'b0, 2'd0, 8'h00); n++;
        end
        chk("reach_toggle", n < 1000, 1'b1);
        cyc(1'b1, 1'b1, 2'd2, 8'h05);
        repeat (50) cyc(1'b1, 1'b0, 2'd2, 8'h00);

        // Async reset mid-count while step is high.
        n = 0;
        while (!m_step && n < 1000) begin
            cyc(1'b1, 1'b0, 2'd0, 8'h00); n++;
        end
        chk("reach_step_high", n < 1000, 1'b1);
        async_reset();
        repeat (3) cyc(1'b1, 1'b0, 2'd0, 8'h00);
        rst_drv = 1'b1;
        cyc(1'b1, 1'b0, 2'd0, 8'h00);
        cyc(1'b1, 1'b0, 2'd1, 8'h00);
        cyc(1'b1, 1'b0, 2'd2, 8'h00);
        cyc(1'b1, 1'b0, 2'd0, 8'h00);

        // Randomized traffic with small periods and sparse cen.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] a;
            logic [7:0] d;
            bit w, c;
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 3) != 0);
            d = (a == 2'd1) ? (($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00)
                            : 8'($urandom_range(0, 9));
            cyc(c, w, a, d);
        end
        cyc(1'b0, 1'b0, 2'd0, 8'h00);
        @(posedge clk);
        #2 mon_en = 1'b0;
        chk("sb_drained", sb_q.size(), 0);

        // Maximum period with DIV=1: first rising edge 65535 cen after the clear.
        @(negedge clk);
        bus1.cen = 1'b1; bus1.wr = 1'b1; bus1.addr = 2'd0; bus1.din = 8'hFF;
        @(negedge clk);
        bus1.addr = 2'd1;
        @(negedge clk);
        bus1.addr = 2'd2; bus1.din = 8'h00;
        @(negedge clk);
        bus1.wr = 1'b0; bus1.addr = 2'd0;
        chk("div1_restart", bus1.restart, 1'b1);
        chk("div1_null", bus1.null_period, 1'b0);
        n = 0;
        while (n < 70000) begin
            @(posedge clk);
            #1 n++;
            if (bus1.step) break;
        end
        chk("ffff_wrap_cycles", n, 65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
